// File: rtl/adiabatic_pkg.sv
// Shared types and constants for the adiabatic power-clock sequencer.
package adiabatic_pkg;

   localparam int PHASES_PER_PERIOD = 4;

   typedef enum logic [1:0] {
      PH_IDLE = 2'd0,
      PH_UP   = 2'd1,
      PH_HOLD = 2'd2,
      PH_DOWN = 2'd3
   } phase_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   // Stage k lags stage 0 by k phases; the 2-bit subtraction wraps modulo the period.
   function automatic phase_t stage_phase(input logic [1:0] p, input int k);
      return phase_t'(p - 2'(k));
   endfunction

endpackage

// File: rtl/adiabatic_phase_dec.sv
// Per-stage decode of a power-clock phase into clkpos/clkneg/ramp levels.
// Build option ADIABATIC_XMODEL_EN: the rails read as X while ramping.
module adiabatic_phase_dec
   import adiabatic_pkg::*;
(
   input  phase_t phase,
   input  logic   active,
   output logic   clkpos,
   output logic   clkneg,
   output logic   ramp
);

   // Phase-to-rail mapping; an inactive stage is parked at IDLE levels.
   always_comb begin
      clkpos = 1'b0;
      clkneg = 1'b1;
      ramp   = 1'b0;
      if (active) begin
         case (phase)
            PH_UP, PH_DOWN: begin
               ramp = 1'b1;
`ifdef ADIABATIC_XMODEL_EN
               clkpos = 1'bx;
               clkneg = 1'bx;
`else
               clkpos = 1'b1;
               clkneg = 1'b0;
`endif
            end
            PH_HOLD: begin
               clkpos = 1'b1;
               clkneg = 1'b0;
               ramp   = 1'b0;
            end
            default: begin
               clkpos = 1'b0;
               clkneg = 1'b1;
               ramp   = 1'b0;
            end
         endcase
      end else begin
         clkpos = 1'b0;
         clkneg = 1'b1;
         ramp   = 1'b0;
      end
   end

endmodule

// File: rtl/adiabatic_clk_seq.sv
// Four-phase adiabatic power-clock sequencer: staggered stage clocks, launch/sample strobes.
// Build option ADIABATIC_XMODEL_EN selects the X-during-ramp rail model (see adiabatic_phase_dec).
module adiabatic_clk_seq
   import adiabatic_pkg::*;
#(
   parameter int NSTAGE = 4,
   parameter int DWELL  = 1,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [CNT_W-1:0]  n_cycles,
   output logic              busy,
   output logic [NSTAGE-1:0] clkpos,
   output logic [NSTAGE-1:0] clkneg,
   output logic [NSTAGE-1:0] ramp,
   output logic              in_load,
   output logic              out_valid,
   output logic              done
);

   localparam int              DW_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
   localparam logic [1:0]      PH_LAST = 2'(PHASES_PER_PERIOD - 1);

   state_t             state_r, state_s;
   logic [1:0]         ph_r, ph_s;
   logic [DW_W-1:0]    dw_r, dw_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s;
   logic [CNT_W-1:0]   n_r, n_s;
   logic [NSTAGE-1:0]  act_r, act_s;
   logic               advance_s, drain_s, keep0_s, done_s;
   logic [NSTAGE-1:0]  clkpos_s, clkneg_s, ramp_s;
   logic               in_load_s, out_valid_s;

   // Next-state: dwell/phase timing, stage-activity wavefront, run/drain/done sequencing.
   always_comb begin
      state_s   = state_r;
      ph_s      = ph_r;
      dw_s      = dw_r;
      cnt_s     = cnt_r;
      n_s       = n_r;
      act_s     = act_r;
      done_s    = 1'b0;
      drain_s   = 1'b0;
      keep0_s   = 1'b0;
      advance_s = (dw_r == DW_LAST);
      cnt_inc_s = cnt_r + CNT_W'(1);
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_s = S_RUN;
               ph_s    = 2'd0;
               dw_s    = {DW_W{1'b0}};
               cnt_s   = {CNT_W{1'b0}};
               n_s     = n_cycles;
               act_s   = NSTAGE'(1'b1);
            end else begin
               state_s = S_IDLE;
            end
         end
         S_RUN, S_DRAIN: begin
            drain_s = (state_r == S_DRAIN) || stop ||
                      (advance_s && (ph_r == PH_LAST) &&
                       (n_r != {CNT_W{1'b0}}) && (cnt_inc_s == n_r));
            // Stage 0 drops out at the first period boundary once draining; the rest follow one phase apart.
            keep0_s = act_r[0] && !(drain_s && (ph_r == PH_LAST));
            if (advance_s) begin
               dw_s  = {DW_W{1'b0}};
               ph_s  = ph_r + 2'd1;
               act_s = (act_r << 1'b1) | NSTAGE'(keep0_s);
               if ((ph_r == PH_LAST) && (state_r == S_RUN)) begin
                  cnt_s = cnt_inc_s;
               end else begin
                  cnt_s = cnt_r;
               end
            end else begin
               dw_s = dw_r + DW_W'(1'b1);
            end
            state_s = drain_s ? S_DRAIN : S_RUN;
            if (act_s == {NSTAGE{1'b0}}) begin
               state_s = S_IDLE;
               done_s  = 1'b1;
            end else begin
               done_s  = 1'b0;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      adiabatic_phase_dec u_dec (
         .phase  (stage_phase(ph_s, k)),
         .active (act_s[k]),
         .clkpos (clkpos_s[k]),
         .clkneg (clkneg_s[k]),
         .ramp   (ramp_s[k])
      );
   end

   assign in_load_s   = (state_s == S_RUN) && act_s[0] && (ph_s == 2'd0) && (dw_s == DW_LAST);
   assign out_valid_s = act_s[NSTAGE-1] && (stage_phase(ph_s, NSTAGE - 1) == PH_HOLD) &&
                        (dw_s == DW_LAST);

   // State and output registers; outputs are registered from the next-state decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         ph_r      <= 2'd0;
         dw_r      <= {DW_W{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         n_r       <= {CNT_W{1'b0}};
         act_r     <= {NSTAGE{1'b0}};
         busy      <= 1'b0;
         clkpos    <= {NSTAGE{1'b0}};
         clkneg    <= {NSTAGE{1'b1}};
         ramp      <= {NSTAGE{1'b0}};
         in_load   <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_r   <= state_s;
         ph_r      <= ph_s;
         dw_r      <= dw_s;
         cnt_r     <= cnt_s;
         n_r       <= n_s;
         act_r     <= act_s;
         busy      <= (state_s != S_IDLE);
         clkpos    <= clkpos_s;
         clkneg    <= clkneg_s;
         ramp      <= ramp_s;
         in_load   <= in_load_s;
         out_valid <= out_valid_s;
         done      <= done_s;
      end
   end

endmodule

// File: doc/adiabatic_clk_seq.md
# adiabatic_clk_seq

Power-clock sequencer for the adiabatic ALU datapath. Generates the four-phase trapezoidal power clocks (clkpos/clkneg pairs plus ramp flags) that drive a chain of NSTAGE adiabatic gate stages, each stage lagging the previous by one phase. It also emits the operand-launch and result-sample strobes that the upstream operand driver and downstream checker use. It sits directly upstream of the adiabatic gate cells and owns their evaluate/hold/recover sequencing.

## Interface
- NSTAGE, 4: number of power-clocked stages (≥1).
- DWELL, 1: clk cycles spent in each phase (≥1).
- CNT_W, 8: width of the evaluation-cycle counter.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run
- stop  in  1  one-cycle pulse; requests orderly drain
- n_cycles  in  CNT_W  evaluation periods to run; 0 = free-run until stop
- busy  out  1  run or drain in progress
- clkpos  out  NSTAGE  positive power clock per stage
- clkneg  out  NSTAGE  complementary power clock per stage
- ramp  out  NSTAGE  stage is in UP or DOWN phase
- in_load  out  1  strobe: apply new operand to stage 0
- out_valid  out  1  strobe: last stage output is stable
- done  out  1  one-cycle pulse at end of run

## Operation
- Phases per stage, in order: IDLE(0), UP(1), HOLD(2), DOWN(3). Period = 4 phases.
- Phase index p increments every DWELL cycles in RUN/DRAIN. Stage k is in phase (p−k) mod 4 once p ≥ k; before that it is IDLE.
- Per-stage mapping: IDLE → clkpos 0, ramp 0. UP/DOWN → ramp 1, clkpos 1. HOLD → clkpos 1, ramp 0. clkneg = ~clkpos always.
- FSM states: S_IDLE, S_RUN, S_DRAIN.
  - S_IDLE: start → S_RUN. n_cycles is latched; p and the dwell counter are cleared.
  - S_RUN: each completed stage-0 period increments the evaluation counter. Entering S_DRAIN on stop, or on counter == latched n_cycles (when nonzero).
  - S_DRAIN: stage 0 finishes its current period, then stays IDLE. Stage k stops after completing the same number of periods as stage 0. After the last stage's final DOWN phase, pulse done, then go to S_IDLE.
- in_load: 1-cycle pulse on the last cycle of each stage-0 IDLE phase, S_RUN only.
- out_valid: 1-cycle pulse on the last cycle of each last-stage HOLD phase, in both RUN and DRAIN.
- busy is 1 in S_RUN/S_DRAIN and 0 in the done cycle.
- Boundary behaviour:
  - start while busy is ignored.
  - stop in S_IDLE or S_DRAIN is ignored.
  - stop coinciding with counter terminal produces a single drain.
  - rst mid-run forces reset values on the next edge; no done is emitted.

## Timing
- Reset values: busy 0, clkpos all 0, clkneg all 1, ramp all 0, in_load 0, out_valid 0, done 0, FSM S_IDLE.
- All outputs are registered.
- start sampled at edge t: first RUN cycle is t+1 (p=0). First in_load at t+DWELL. First out_valid at t+DWELL·(NSTAGE+2).
- With n_cycles=N and no stop: done at t+1+DWELL·(4N+NSTAGE−1).

## Configuration
- ADIABATIC_XMODEL_EN defined: during UP/DOWN, clkpos and clkneg drive 1'bx. This is the simulation model matching the gate cells' mid-ramp behaviour. ramp still asserts.
- Not defined: mapping exactly as in Operation; fully synthesizable, no X.

## Structure
- Package adiabatic_pkg:
  - phase_t enum (IDLE/UP/HOLD/DOWN)
  - FSM state enum
  - PHASES_PER_PERIOD = 4 constant
- Sub-module adiabatic_phase_dec: maps phase_t plus an active flag to clkpos/clkneg/ramp. Instantiated NSTAGE times. Owns the ADIABATIC_XMODEL_EN branch.

## Test plan
- Reset: hold rst 3 cycles → clkpos=0000, clkneg=1111, busy=0, all strobes 0.
- NSTAGE=4, DWELL=1, n_cycles=1, start at t → in_load at t+1, out_valid at t+6, done at t+8, busy low at t+8, stage phases staggered by one cycle.
- DWELL=3, n_cycles=2 → every phase lasts 3 cycles; out_valid at t+18 and t+30; done at t+1+3·11=t+34.
- n_cycles=0, stop pulsed mid-HOLD of stage 0 → stage 0 completes its period; remaining stages drain in order; exactly one done; no further in_load.
- start during busy plus rst at a random RUN cycle → start is ignored; after rst, outputs equal reset values next cycle and no done appears.
- ADIABATIC_XMODEL_EN defined → clkpos[k]===1'bx exactly while ramp[k]=1.
